// File: rtl/instruction_sequencer_if.sv
// Program-memory bus between the instruction sequencer (master) and program memory (slave).
interface instruction_sequencer_if #(
  parameter int PC_WIDTH = 4
);
  logic [PC_WIDTH-1:0] pc_addr;
  logic                mem_req;
  logic [7:0]          instr_data;

  modport master (output pc_addr, mem_req, input instr_data);
  modport slave  (input pc_addr, mem_req, output instr_data);
endinterface

// File: rtl/instruction_sequencer.sv
// Four-phase fetch/decode/execute/writeback sequencer over a small program memory.
// All control outputs are registered and are loaded with the value for the state being entered.
module instruction_sequencer #(
  parameter int PC_WIDTH  = 4,
  parameter int PROG_LAST = 15
) (
  input  logic                        CLKin,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        halt_req,
  instruction_sequencer_if.master     mem,
  output logic [3:0]                  opcode_out,
  output logic [3:0]                  operand_out,
  output logic                        exec_en,
  output logic                        busy,
  output logic                        done
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_DONE
  } state_t;

  localparam logic [PC_WIDTH-1:0] LAST = PROG_LAST[PC_WIDTH-1:0];

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic                mem_req;

  assign mem.pc_addr = pc;
  assign mem.mem_req = mem_req;
  assign opcode_out  = ir[7:4];
  assign operand_out = ir[3:0];

  always_ff @(posedge CLKin) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      mem_req <= 1'b0;
      exec_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      exec_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
          busy    <= 1'b1;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir      <= mem.instr_data;
          state   <= S_EXECUTE;
          exec_en <= 1'b1;
        end
        S_EXECUTE: state <= S_WRITEBACK;
        S_WRITEBACK: begin
          // Last-address check wins over a pause so the program always terminates in DONE.
          if (pc == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
            if (halt_req) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_FETCH;
              mem_req <= 1'b1;
            end
          end
        end
        S_DONE: if (start) begin
          pc      <= '0;
          state   <= S_FETCH;
          mem_req <= 1'b1;
          busy    <= 1'b1;
          done    <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed scenarios plus random start/halt/reset traffic, checked every cycle against a
// phase-counting reference model of the sequencer.
module tb_instruction_sequencer;
  localparam int PW   = 4;
  localparam int LAST = 3;

  logic       CLKin = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic [3:0] opcode_out, operand_out;
  logic       exec_en, busy, done;

  instruction_sequencer_if #(.PC_WIDTH(PW)) bus();

  instruction_sequencer #(.PC_WIDTH(PW), .PROG_LAST(LAST)) dut (
    .CLKin(CLKin), .reset(reset), .start(start), .halt_req(halt_req), .mem(bus),
    .opcode_out(opcode_out), .operand_out(operand_out),
    .exec_en(exec_en), .busy(busy), .done(done)
  );

  always #5 CLKin = ~CLKin;

  // Program memory: data appears the cycle after the read strobe.
  logic [7:0] mem [16];
  always @(posedge CLKin) if (bus.mem_req) bus.instr_data <= mem[bus.pc_addr];

  // Reference model: running flag, cycle offset within the current instruction, finished flag.
  bit       m_run, m_fin;
  int       m_t, m_pc;
  bit [7:0] m_ir;

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      m_run = 0; m_fin = 0; m_t = 0; m_pc = 0; m_ir = 0;
    end else if (!m_run) begin
      if (start) begin
        if (m_fin) m_pc = 0;
        m_fin = 0; m_run = 1; m_t = 0;
      end
    end else begin
      case (m_t)
        0: m_t = 1;
        1: begin m_ir = mem[m_pc]; m_t = 2; end
        2: m_t = 3;
        default: begin
          if (m_pc == LAST) begin
            m_run = 0; m_fin = 1;
          end else begin
            m_pc = (m_pc + 1) % (1 << PW);
            if (halt_req) m_run = 0;
            else m_t = 0;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    chk("mem_req",  32'(bus.mem_req), 32'(m_run && m_t == 0));
    chk("exec_en",  32'(exec_en),     32'(m_run && m_t == 2));
    chk("busy",     32'(busy),        32'(m_run));
    chk("done",     32'(done),        32'(m_fin));
    chk("pc_addr",  32'(bus.pc_addr), 32'(m_pc));
    chk("opcode",   32'(opcode_out),  32'(m_ir[7:4]));
    chk("operand",  32'(operand_out), 32'(m_ir[3:0]));
  endtask

  task automatic tick();
    @(posedge CLKin);
    model_step();
    @(negedge CLKin);
    cyc++;
    compare_all();
  endtask

  initial begin
    int g, n_ex, last;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h5A;

    // Reset and idle
    reset = 0; tick(); tick();
    reset = 1; tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_op", 32'(opcode_out), 0);

    // One-cycle start pulse, first instruction 0x5A
    start = 1; tick(); start = 0;
    chk("fetch_req", 32'(bus.mem_req), 1);
    chk("fetch_addr", 32'(bus.pc_addr), 0);
    tick();
    chk("decode_en", 32'(exec_en), 0);
    tick();
    chk("ex_en", 32'(exec_en), 1);
    chk("ex_op", 32'(opcode_out), 5);
    chk("ex_opnd", 32'(operand_out), 32'hA);
    last = cyc; n_ex = 1;
    tick();
    chk("wb_en", 32'(exec_en), 0);
    tick();
    chk("fetch1_req", 32'(bus.mem_req), 1);
    chk("fetch1_addr", 32'(bus.pc_addr), 1);

    // Finish the program: 4 execute pulses, 4 cycles apart
    g = 0;
    while (!done && g < 40) begin
      tick(); g++;
      if (exec_en) begin
        chk("exec_gap", 32'(cyc - last), 4);
        last = cyc; n_ex++;
      end
    end
    chk("done_in_time", 32'(g < 40), 1);
    chk("n_exec", 32'(n_ex), 4);
    chk("done_flag", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_pc", 32'(bus.pc_addr), LAST);
    halt_req = 1; tick(); tick(); tick(); halt_req = 0;
    chk("done_hold", 32'(done), 1);
    chk("done_hold_pc", 32'(bus.pc_addr), LAST);

    // Restart from DONE, pause in writeback of pc=1
    start = 1; tick(); start = 0;
    chk("restart_pc", 32'(bus.pc_addr), 0);
    chk("restart_req", 32'(bus.mem_req), 1);
    g = 0;
    do begin halt_req = (m_pc == 1); tick(); g++; end while (busy && g < 40);
    halt_req = 0;
    chk("halt_in_time", 32'(g < 40), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_done", 32'(done), 0);
    chk("halt_pc", 32'(bus.pc_addr), 2);
    tick(); tick();
    start = 1; tick(); start = 0;
    chk("resume_req", 32'(bus.mem_req), 1);
    chk("resume_pc", 32'(bus.pc_addr), 2);

    // Pause request coinciding with the last address
    g = 0;
    do begin halt_req = (m_pc == LAST); tick(); g++; end while (busy && g < 40);
    halt_req = 0;
    chk("last_halt_done", 32'(done), 1);
    chk("last_halt_pc", 32'(bus.pc_addr), LAST);

    // Reset during EXECUTE
    start = 1; tick(); start = 0;
    g = 0;
    while (!exec_en && g < 10) begin tick(); g++; end
    chk("reach_exec", 32'(exec_en), 1);
    reset = 0; tick(); reset = 1;
    chk("rst_exec", 32'(exec_en), 0);
    chk("rst_pc", 32'(bus.pc_addr), 0);
    chk("rst_op", 32'(opcode_out), 0);
    chk("rst_opnd", 32'(operand_out), 0);
    chk("rst_busy", 32'(busy), 0);
    n_ex = 0;
    repeat (10) begin tick(); if (exec_en) n_ex++; end
    chk("no_exec_after_rst", 32'(n_ex), 0);

    // Random traffic
    repeat (2000) begin
      start    = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 3) == 0);
      reset    = !($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
